// File: rtl/spi_byte_engine.sv
// spi_byte_engine
//   SPI mode-0 (CPOL=0, CPHA=0) master byte shifter. One byte is launched per
//   accepted start pulse. The byte goes out MSB-first on mosi and miso is
//   shifted in at the same time. Each received byte is pushed to an external
//   RX FIFO. Chip select belongs to the upstream controller and is not driven here.
//
// Parameters
//   CLK_DIV     clk cycles per sclk half-period (1..255)
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   start       launch one byte (ignored while active)
//   tx_data     byte to send, captured when start is accepted
//   clk_enable  0 freezes the divider, sclk and mosi while a byte is in flight
//   miso        serial data from the slave
//   rx_full     RX FIFO full, looked at only on the final edge of a byte
//   sclk        SPI clock, idles low
//   mosi        serial data to the slave, holds its last bit between bytes
//   active      high while a byte is in flight
//   rx_write    one-cycle push strobe to the RX FIFO
//   rx_wdata    received byte, held after the push
//   done        one-cycle pulse at the end of every byte (pushed or dropped)
//   overflow    sticky flag: a byte completed while rx_full was high
module spi_byte_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       clk_enable,
  input  logic       miso,
  input  logic       rx_full,
  output logic       sclk,
  output logic       mosi,
  output logic       active,
  output logic       rx_write,
  output logic [7:0] rx_wdata,
  output logic       done,
  output logic       overflow
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SCLK_HI = 3'd2,
    ST_SCLK_LO = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        active_q, active_d;
  logic        rx_write_q, rx_write_d;
  logic [7:0]  rx_wdata_q, rx_wdata_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;
  logic        phase_end_s;

  // A phase ends only on an enabled cycle with the divider at its top value.
  assign phase_end_s = clk_enable && (div_cnt_q == DIV_MAX);

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= 8'd0;
      bit_cnt_q  <= 3'd0;
      tx_sr_q    <= 8'd0;
      rx_sr_q    <= 8'd0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      active_q   <= 1'b0;
      rx_write_q <= 1'b0;
      rx_wdata_q <= 8'd0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      active_q   <= active_d;
      rx_write_q <= rx_write_d;
      rx_wdata_q <= rx_wdata_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state, divider and shifter logic.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    active_d   = active_q;
    rx_write_d = 1'b0;
    rx_wdata_d = rx_wdata_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;

    // The divider runs in every busy state but freezes while clk_enable is low.
    if (state_q == ST_IDLE) begin
      div_cnt_d = 8'd0;
    end else if (phase_end_s) begin
      div_cnt_d = 8'd0;
    end else if (clk_enable) begin
      div_cnt_d = div_cnt_q + 8'd1;
    end else begin
      div_cnt_d = div_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_sr_d   = tx_data;
          mosi_d    = tx_data[7];
          bit_cnt_d = 3'd7;
          active_d  = 1'b1;
          state_d   = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // SETUP and SCLK_LO both end with a rising edge that samples miso.
      ST_SETUP, ST_SCLK_LO: begin
        if (phase_end_s) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[6:0], miso};
          state_d = ST_SCLK_HI;
        end else begin
          state_d = state_q;
        end
      end
      ST_SCLK_HI: begin
        if (phase_end_s) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == 3'd0) begin
            state_d = ST_FINISH;
          end else begin
            // Next bit goes out on the falling edge; tx_sr[7] is the bit just sent.
            bit_cnt_d = bit_cnt_q - 3'd1;
            tx_sr_d   = {tx_sr_q[6:0], 1'b0};
            mosi_d    = tx_sr_q[6];
            state_d   = ST_SCLK_LO;
          end
        end else begin
          state_d = ST_SCLK_HI;
        end
      end
      ST_FINISH: begin
        if (phase_end_s) begin
          active_d = 1'b0;
          done_d   = 1'b1;
          if (!rx_full) begin
            rx_write_d = 1'b1;
            rx_wdata_d = rx_sr_q;
          end else begin
            overflow_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FINISH;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        active_d = 1'b0;
        sclk_d   = 1'b0;
      end
    endcase
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign active   = active_q;
  assign rx_write = rx_write_q;
  assign rx_wdata = rx_wdata_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine
//   Self-checking bench for spi_byte_engine. A slave model answers on miso.
//   An expectation model predicts each byte from the SPI mode-0 rules:
//   mosi bits MSB-first, 8 rising edges, active length of 17*CLK_DIV plus
//   paused cycles, push or drop decided by rx_full, and a sticky overflow.
module tb_spi_byte_engine;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clk_enable = 1'b1;
  logic       miso;
  logic       rx_full = 1'b0;
  logic       sclk, mosi, active, rx_write, done, overflow;
  logic [7:0] rx_wdata;

  spi_byte_engine #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .clk_enable(clk_enable), .miso(miso), .rx_full(rx_full),
    .sclk(sclk), .mosi(mosi), .active(active), .rx_write(rx_write),
    .rx_wdata(rx_wdata), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Slave side: counts rising sclk edges and records mosi on each one.
  int         rise_cnt = 0;
  logic [7:0] mosi_sh = 8'h00;
  int         base = 0;
  logic [7:0] slave_byte = 8'h00;
  logic       exp_ovf = 1'b0;

  always @(posedge sclk) begin
    mosi_sh  = {mosi_sh[6:0], mosi};
    rise_cnt = rise_cnt + 1;
  end

  // Slave presents bit (7 - edges seen) ahead of the next rising edge.
  always_comb begin
    int idx;
    idx  = rise_cnt - base;
    miso = 1'b0;
    if (idx >= 0 && idx < 8) miso = slave_byte[3'(7 - idx)];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pmode: 0 no pause, 1 random pauses, 2 twenty paused cycles after the 3rd rising edge.
  task automatic run_byte(input logic [7:0] tx, input logic [7:0] sb, input logic full,
                          input int pmode, input logic mid_start);
    int   dur, paused, dones, writes, given;
    logic prev_s, prev_m, froze, ended, ce;
    base       = rise_cnt;
    slave_byte = sb;
    rx_full    = full;
    tx_data    = tx;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("active_after_start", 32'(active), 32'd1);
    dur = 0; paused = 0; dones = 0; writes = 0; given = 0;
    froze = 1'b0; ended = 1'b0; prev_s = sclk; prev_m = mosi;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (froze) begin
        check_eq("pause_sclk", 32'(sclk), 32'(prev_s));
        check_eq("pause_mosi", 32'(mosi), 32'(prev_m));
      end
      if (!active) begin
        ended = 1'b1;
        break;
      end
      if (done) dones++;
      if (rx_write) writes++;
      dur++;
      prev_s  = sclk;
      prev_m  = mosi;
      start   = 1'b0;
      tx_data = tx;
      if (mid_start && dur == 30) begin
        start   = 1'b1;
        tx_data = 8'hFF;
      end
      ce = 1'b1;
      if (pmode == 1) ce = ($urandom_range(0, 3) != 0);
      if (pmode == 2 && (rise_cnt - base) >= 3 && given < 20) begin
        ce = 1'b0;
        given++;
      end
      clk_enable = ce;
      froze = !ce;
      if (!ce) paused++;
      @(negedge clk);
    end
    start      = 1'b0;
    clk_enable = 1'b1;
    check_eq("byte_ended", 32'(ended), 32'd1);
    if (full) exp_ovf = 1'b1;
    check_eq("active_len", 32'(dur), 32'(17 * CLK_DIV + paused));
    check_eq("rise_edges", 32'(rise_cnt - base), 32'd8);
    check_eq("mosi_bits", 32'(mosi_sh), 32'(tx));
    check_eq("done_end", 32'(done), 32'd1);
    check_eq("rx_write_end", 32'(rx_write), 32'(!full));
    if (!full) check_eq("rx_wdata", 32'(rx_wdata), 32'(sb));
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    check_eq("no_early_done", 32'(dones), 32'd0);
    check_eq("no_early_write", 32'(writes), 32'd0);
    check_eq("sclk_idle", 32'(sclk), 32'd0);
  endtask

  task automatic run_reset_abort(input logic [7:0] tx, input logic [7:0] sb);
    logic hit;
    base       = rise_cnt;
    slave_byte = sb;
    rx_full    = 1'b0;
    tx_data    = tx;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit   = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if ((rise_cnt - base) >= 5) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("reach_5th_edge", 32'(hit), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_sclk", 32'(sclk), 32'd0);
    check_eq("abort_mosi", 32'(mosi), 32'd0);
    check_eq("abort_active", 32'(active), 32'd0);
    check_eq("abort_rx_write", 32'(rx_write), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_overflow", 32'(overflow), 32'd0);
    exp_ovf = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_abort_done", 32'(done), 32'd0);
    check_eq("post_abort_write", 32'(rx_write), 32'd0);
  endtask

  initial begin
    logic [7:0] t, s;
    logic       f;
    repeat (3) @(negedge clk);
    check_eq("rst_sclk", 32'(sclk), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_active", 32'(active), 32'd0);
    check_eq("rst_rx_write", 32'(rx_write), 32'd0);
    check_eq("rst_rx_wdata", 32'(rx_wdata), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_byte(8'h0B, 8'hA5, 1'b0, 0, 1'b0);
    // Back-to-back controller sequence: each start lands the cycle after active falls.
    run_byte(8'h0B, 8'(($urandom)), 1'b0, 0, 1'b0);
    run_byte(8'h14, 8'(($urandom)), 1'b0, 0, 1'b0);
    run_byte(8'h00, 8'(($urandom)), 1'b0, 0, 1'b0);
    run_byte(8'h0B, 8'(($urandom)), 1'b0, 0, 1'b1);
    run_byte(8'(($urandom)), 8'h3C, 1'b1, 0, 1'b0);
    run_byte(8'(($urandom)), 8'(($urandom)), 1'b0, 0, 1'b0);
    run_byte(8'(($urandom)), 8'(($urandom)), 1'b0, 2, 1'b0);
    run_reset_abort(8'h0B, 8'hC3);
    run_byte(8'h5A, 8'(($urandom)), 1'b0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      t = 8'($urandom);
      s = 8'($urandom);
      f = ($urandom_range(0, 4) == 0);
      run_byte(t, s, f, int'($urandom_range(0, 1)), 1'(($urandom_range(0, 3) == 0)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
